// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - debounced set/clear command generator for a downstream NOR SR latch
//
// Purpose:
//   Turns two raw, bouncy request inputs into clean, non-overlapping S/R
//   pulses for an external NOR SR latch. It also tracks the latch state that
//   those pulses should produce.
//   Each raw input goes through a 2-flop synchronizer and then a stable-count
//   debouncer. A rising debounced edge is a one-cycle request.
//   The command FSM (INIT/IDLE/SET_PULSE/CLR_PULSE/GAP) issues the pulses.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   set_in   in   raw asynchronous set request
//   clr_in   in   raw asynchronous clear request
//   S        out  set drive to the latch (registered)
//   R        out  reset drive to the latch (registered)
//   q_model  out  expected latch Q after the last completed command
//   busy     out  FSM is not in IDLE
//   conflict out  sticky: set and clear requested on the same edge in IDLE
//   dropped  out  sticky: a request arrived while not in IDLE

module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic S,
  output logic R,
  output logic q_model,
  output logic busy,
  output logic conflict,
  output logic dropped
);

  localparam logic [7:0] DEB_MAX   = 8'(DEB_CYCLES);
  localparam logic [7:0] PULSE_MAX = 8'(PULSE_CYCLES);

  // Channel 0 is set, channel 1 is clear.
  localparam int SET_CH = 0;
  localparam int CLR_CH = 1;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SET_PULSE = 3'd2,
    ST_CLR_PULSE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers and debouncers
  // ---------------------------------------------------------------------------
  logic [1:0]      raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      deb_q;
  logic [1:0]      deb_d;
  logic [1:0]      deb_prev_q;
  logic [1:0][7:0] deb_cnt_q;
  logic [1:0][7:0] deb_cnt_d;

  assign raw = {clr_in, set_in};

  // The counter counts edges on which the synchronized level has differed from
  // the debounced level. The toggle happens on the edge after the count
  // reaches DEB_CYCLES. This gives the debounced change at k+2+DEB_CYCLES,
  // where k is the first edge that samples the new raw level.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        deb_d[i]     = ~deb_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // One-cycle requests on rising debounced edges only.
  logic set_req;
  logic clr_req;
  logic any_req;

  assign set_req = deb_q[SET_CH] & ~deb_prev_q[SET_CH];
  assign clr_req = deb_q[CLR_CH] & ~deb_prev_q[CLR_CH];
  assign any_req = set_req | clr_req;

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [7:0] pulse_cnt_q;
  logic [7:0] pulse_cnt_d;
  logic       s_q;
  logic       s_d;
  logic       r_q;
  logic       r_d;
  logic       q_model_q;
  logic       q_model_d;
  logic       conflict_q;
  logic       conflict_d;
  logic       dropped_q;
  logic       dropped_d;

  // State register. The outputs are also registered here. As a result, S and R
  // fall on the same edge that reset is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      pulse_cnt_q <= '0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      q_model_q   <= 1'b0;
      conflict_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      s_q         <= s_d;
      r_q         <= r_d;
      q_model_q   <= q_model_d;
      conflict_q  <= conflict_d;
      dropped_q   <= dropped_d;
    end
  end

  // Next-state logic.
  // A pulse leaves its state once pulse_cnt reaches PULSE_CYCLES.
  // Commands from IDLE enter with the count at 1, so they last PULSE_CYCLES
  // cycles. INIT starts from 0 out of reset. The reset cycles produce no R
  // output, so INIT still drives R for PULSE_CYCLES cycles after release.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    unique case (state_q)
      ST_INIT, ST_SET_PULSE, ST_CLR_PULSE: begin
        if (pulse_cnt_q >= PULSE_MAX) begin
          state_d     = ST_GAP;
          pulse_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
      end
      ST_IDLE: begin
        if (set_req && !clr_req) begin
          state_d     = ST_SET_PULSE;
          pulse_cnt_d = 8'd1;
        end else if (clr_req && !set_req) begin
          state_d     = ST_CLR_PULSE;
          pulse_cnt_d = 8'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_INIT;
        pulse_cnt_d = '0;
      end
    endcase
  end

  // Output logic.
  // S and R are decoded from the next state, so they line up with the state
  // register. They are mutually exclusive by construction.
  always_comb begin
    s_d        = (state_d == ST_SET_PULSE);
    r_d        = (state_d == ST_INIT) || (state_d == ST_CLR_PULSE);
    q_model_d  = q_model_q;
    conflict_d = conflict_q;
    dropped_d  = dropped_q;

    if (state_d == ST_GAP && state_q != ST_GAP) begin
      q_model_d = (state_q == ST_SET_PULSE);
    end

    if (state_q == ST_IDLE) begin
      if (set_req && clr_req) begin
        conflict_d = 1'b1;
      end
    end else if (any_req) begin
      dropped_d = 1'b1;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign q_model  = q_model_q;
  assign busy     = (state_q != ST_IDLE);
  assign conflict = conflict_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb/tb_sr_cmd_gen.sv - directed self-checking bench for sr_cmd_gen
//
// Purpose:
//   Drives reset, set, bounce, conflict, drop/recovery and mid-pulse reset
//   sequences at default parameters. It compares the outputs against
//   hand-computed cycle positions.
//
// Ports: none (top-level bench).

module tb_sr_cmd_gen;

  logic clk;
  logic rst;
  logic set_in;
  logic clr_in;
  logic S;
  logic R;
  logic q_model;
  logic busy;
  logic conflict;
  logic dropped;

  int n_checks = 0;
  int n_errors = 0;

  sr_cmd_gen #(
    .DEB_CYCLES  (4),
    .PULSE_CYCLES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .set_in  (set_in),
    .clr_in  (clr_in),
    .S       (S),
    .R       (R),
    .q_model (q_model),
    .busy    (busy),
    .conflict(conflict),
    .dropped (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // S and R must never overlap.
  always @(negedge clk) begin
    check("sr_excl", S & R, 1'b0);
  end

  initial begin
    rst    = 1'b1;
    set_in = 1'b0;
    clr_in = 1'b0;

    // Reset: hold 3 edges, then INIT drives R for 2 cycles, then GAP, then IDLE.
    step(3);
    check("rst_S", S, 1'b0);
    check("rst_R", R, 1'b0);
    check("rst_q", q_model, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_conflict", conflict, 1'b0);
    check("rst_dropped", dropped, 1'b0);
    rst = 1'b0;
    step(1);
    check("init_R1", R, 1'b1);
    check("init_S1", S, 1'b0);
    step(1);
    check("init_R2", R, 1'b1);
    step(1);
    check("gap_R", R, 1'b0);
    check("gap_busy", busy, 1'b1);
    step(1);
    check("idle_busy", busy, 1'b0);
    check("idle_q", q_model, 1'b0);
    check("idle_S", S, 1'b0);

    // Set: set_in first sampled at edge k. S is high at k+7 and k+8, q is 1
    // at k+9, and busy drops at k+10.
    set_in = 1'b1;
    step(7);              // after edge k+6
    check("set_S_early", S, 1'b0);
    step(1);              // k+7
    check("set_S_k7", S, 1'b1);
    check("set_busy_k7", busy, 1'b1);
    step(1);              // k+8
    check("set_S_k8", S, 1'b1);
    check("set_R_k8", R, 1'b0);
    step(1);              // k+9
    check("set_S_k9", S, 1'b0);
    check("set_q_k9", q_model, 1'b1);
    check("set_busy_k9", busy, 1'b1);
    step(1);              // k+10
    check("set_busy_k10", busy, 1'b0);
    set_in = 1'b0;
    step(10);
    check("set_fall_busy", busy, 1'b0);
    check("set_fall_q", q_model, 1'b1);

    // Bounce: toggle every 2 cycles for 20 cycles, never stable long enough.
    for (int i = 0; i < 20; i++) begin
      set_in = ((i / 2) % 2 == 0);
      step(1);
      check("bounce_S", S, 1'b0);
    end
    set_in = 1'b0;
    step(10);
    check("bounce_S_end", S, 1'b0);
    check("bounce_busy", busy, 1'b0);
    check("bounce_conflict", conflict, 1'b0);
    check("bounce_dropped", dropped, 1'b0);

    // Conflict: both rise together.
    set_in = 1'b1;
    clr_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("conf_S", S, 1'b0);
      check("conf_R", R, 1'b0);
    end
    check("conf_flag", conflict, 1'b1);
    check("conf_q", q_model, 1'b1);
    check("conf_dropped", dropped, 1'b0);
    check("conf_busy", busy, 1'b0);
    set_in = 1'b0;
    clr_in = 1'b0;
    step(10);
    check("conf_sticky", conflict, 1'b1);

    // Drop: clr request lands during SET_PULSE.
    set_in = 1'b1;
    step(1);              // edge k
    clr_in = 1'b1;
    step(6);              // k+6
    check("drop_S_k6", S, 1'b0);
    step(1);              // k+7
    check("drop_S_k7", S, 1'b1);
    check("drop_flag_k7", dropped, 1'b0);
    step(1);              // k+8
    check("drop_flag_k8", dropped, 1'b1);
    check("drop_S_k8", S, 1'b1);
    check("drop_R_k8", R, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("drop_noR", R, 1'b0);
    end
    check("drop_q", q_model, 1'b1);
    set_in = 1'b0;
    clr_in = 1'b0;
    step(10);
    check("drop_sticky", dropped, 1'b1);

    // Recovery: a clean clear gives a 2-cycle R pulse and q=0.
    clr_in = 1'b1;
    step(7);              // j+6
    check("clr_R_j6", R, 1'b0);
    step(1);              // j+7
    check("clr_R_j7", R, 1'b1);
    check("clr_S_j7", S, 1'b0);
    step(1);              // j+8
    check("clr_R_j8", R, 1'b1);
    check("clr_q_j8", q_model, 1'b1);
    step(1);              // j+9
    check("clr_R_j9", R, 1'b0);
    check("clr_q_j9", q_model, 1'b0);
    step(1);              // j+10
    check("clr_busy_j10", busy, 1'b0);
    clr_in = 1'b0;
    step(10);

    // Mid-pulse reset: rst sampled at the second edge of SET_PULSE.
    set_in = 1'b1;
    step(8);              // m+7
    check("mid_S_on", S, 1'b1);
    rst    = 1'b1;
    set_in = 1'b0;
    step(1);
    check("mid_S_off", S, 1'b0);
    check("mid_R_off", R, 1'b0);
    check("mid_busy", busy, 1'b1);
    check("mid_q", q_model, 1'b0);
    check("mid_conflict", conflict, 1'b0);
    check("mid_dropped", dropped, 1'b0);
    step(2);
    check("mid_R_hold", R, 1'b0);
    rst = 1'b0;
    step(1);
    check("mid_init_R1", R, 1'b1);
    check("mid_init_S1", S, 1'b0);
    step(1);
    check("mid_init_R2", R, 1'b1);
    step(1);
    check("mid_gap_R", R, 1'b0);
    step(1);
    check("mid_idle_busy", busy, 1'b0);
    check("mid_idle_q", q_model, 1'b0);
    step(10);
    check("mid_final_S", S, 1'b0);
    check("mid_final_dropped", dropped, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 4, meaning consecutive stable samples required before a debounced input changes (legal range 1..255).
REQ-002 The module SHALL have parameter PULSE_CYCLES, default 2, meaning the width in cycles of each S or R command pulse (legal range 1..255).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 The module SHALL have port set_in, input, 1 bit, raw asynchronous set request (e.g. button).
REQ-006 The module SHALL have port clr_in, input, 1 bit, raw asynchronous clear request.
REQ-007 The module SHALL have port S, output, 1 bit, set drive to the downstream NOR SR latch.
REQ-008 The module SHALL have port R, output, 1 bit, reset drive to the downstream NOR SR latch.
REQ-009 The module SHALL have port q_model, output, 1 bit, the expected latch Q after the last completed command.
REQ-010 The module SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-011 The module SHALL have port conflict, output, 1 bit, sticky flag for a simultaneous set and clear request.
REQ-012 The module SHALL have port dropped, output, 1 bit, sticky flag for a request lost while busy.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Debouncing: each synchronized input SHALL have its own counter; the counter increments while sync != debounced and clears when they are equal; the debounced level SHALL toggle when the counter reaches DEB_CYCLES, and the counter SHALL clear on that same edge.
REQ-015 A request SHALL be generated only on a 0->1 transition of a debounced level; falling transitions and held levels SHALL generate nothing.
REQ-016 Latency: with a raw input changed before edge k and held stable, the debounced level SHALL change at edge k+2+DEB_CYCLES, and S (or R) SHALL go high at edge k+3+DEB_CYCLES (k+7 at defaults).
REQ-017 The FSM SHALL have exactly the states INIT, IDLE, SET_PULSE, CLR_PULSE and GAP.
REQ-018 FSM transition from INIT: R=1 for PULSE_CYCLES cycles, then GAP.
REQ-019 FSM transitions from IDLE: a set request goes to SET_PULSE, a clear request goes to CLR_PULSE, and both requests on the same edge set conflict and remain in IDLE.
REQ-020 FSM transitions from SET_PULSE and CLR_PULSE: the state SHALL hold for exactly PULSE_CYCLES cycles, then go to GAP.
REQ-021 FSM transition from GAP: one cycle with S=R=0, then IDLE.
REQ-022 S SHALL be 1 only in SET_PULSE; R SHALL be 1 only in INIT and CLR_PULSE; S and R SHALL never be 1 in the same cycle.
REQ-023 q_model SHALL update on entry to GAP: 1 after SET_PULSE, 0 after CLR_PULSE or INIT.
REQ-024 A request arriving in any state other than IDLE SHALL be discarded, not queued, and SHALL set dropped.
REQ-025 conflict and dropped SHALL remain set until rst.
REQ-026 A request arriving in the same cycle the FSM enters IDLE from GAP SHALL be accepted.

Reset
REQ-027 While rst=1, the module SHALL drive S=0, R=0, q_model=0, busy=1, conflict=0 and dropped=0, clear the synchronizers, the debounced levels and the counters to 0, and hold the FSM in INIT with its pulse counter cleared.
REQ-028 After rst deasserts, the first edge SHALL drive R=1, so the latch is forced to a known Q=0 before any user command.
REQ-029 rst asserted mid-pulse SHALL drop S or R to 0 at that edge, and the sequence SHALL restart at INIT.

Verification
REQ-030 Reset scenario: rst high 3 cycles, then low -> R=1 for 2 cycles, GAP 1 cycle, busy falls, q_model=0, S never asserted.
REQ-031 Set scenario: set_in high at edge k and held (defaults) -> S=1 at edges k+7..k+8, q_model=1 at k+9, busy low at k+10.
REQ-032 Bounce scenario: set_in toggles every 2 cycles for 20 cycles, then settles at 0 -> S stays 0 and no flag is set.
REQ-033 Conflict scenario: set_in and clr_in rise on the same edge and are held -> S=R=0 throughout, conflict=1, q_model unchanged.
REQ-034 Drop and recovery scenario: clr_in rises while a SET_PULSE is active -> dropped=1 and no R pulse; a later clean clr_in -> R pulse of 2 cycles and q_model=0.
REQ-035 Mid-operation reset scenario: rst asserted during cycle 1 of SET_PULSE -> S=0 on that edge, then the INIT R pulse after release; the checker asserts !(S&&R) on every cycle.
